gpio_led_bank: RTL and testbench

GPIO_LED_BANK -- requirements
Module: gpio_led_bank

---
 rtl/gpio_led_bank.sv | 123 ++++++++++++
 tb/tb_gpio_led_bank.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/gpio_led_bank.sv
// GPIO LED bank: per-channel static/PWM/blink LED drive plus debounced inputs
// with one-cycle edge pulses. One debounce lane instance per input channel.

module gpio_led_bank_db #(
  parameter int DB_CYCLES = 1000
) (
  input  logic clk,
  input  logic resetn,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          diff, hit;

  always_comb begin
    diff    = sync_q[1] ^ level_q;
    hit     = diff && (cnt_q == CNT_MAX);
    // Any cycle of agreement restarts qualification; a hit also restarts it.
    cnt_d   = (diff && !hit) ? cnt_q + CW'(1) : '0;
    level_d = level_q ^ hit;
    rise_d  = hit & ~level_q;
    fall_d  = hit &  level_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], pin_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

module gpio_led_bank #(
  parameter int N_LED      = 8,
  parameter int N_IN       = 3,
  parameter int PWM_BITS   = 8,
  parameter int DB_CYCLES  = 1000,
  parameter int BLINK_BITS = 24
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [N_LED-1:0]      led_write,
  input  logic [2*N_LED-1:0]    led_mode,
  input  logic [PWM_BITS-1:0]   led_duty,
  output logic [N_LED-1:0]      io_led,
  input  logic [N_IN-1:0]       pin_in,
  output logic [N_IN-1:0]       pin_level,
  output logic [N_IN-1:0]       pin_rise,
  output logic [N_IN-1:0]       pin_fall
);
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [PWM_BITS-1:0]   duty_q, duty_d;
  logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
  logic [N_LED-1:0]      io_led_q, io_led_d;
  logic                  pwm, blink;

  always_comb begin
    pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
    blink_cnt_d = blink_cnt_q + BLINK_BITS'(1);
    // Duty only latches on the last count so a period never mixes two duties.
    duty_d      = (pwm_cnt_q == '1) ? led_duty : duty_q;
    pwm         = pwm_cnt_q < duty_q;
    blink       = blink_cnt_q[BLINK_BITS-1];
    io_led_d    = '0;
    for (int i = 0; i < N_LED; i++) begin
      case (led_mode[2*i +: 2])
        2'b01:   io_led_d[i] = led_write[i];
        2'b10:   io_led_d[i] = led_write[i] & pwm;
        2'b11:   io_led_d[i] = led_write[i] & blink;
        default: io_led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pwm_cnt_q   <= '0;
      duty_q      <= '0;
      blink_cnt_q <= '0;
      io_led_q    <= '0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      duty_q      <= duty_d;
      blink_cnt_q <= blink_cnt_d;
      io_led_q    <= io_led_d;
    end
  end

  assign io_led = io_led_q;

  for (genvar g = 0; g < N_IN; g++) begin : g_db
    gpio_led_bank_db #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk    (clk),
      .resetn (resetn),
      .pin_i  (pin_in[g]),
      .level_o(pin_level[g]),
      .rise_o (pin_rise[g]),
      .fall_o (pin_fall[g])
    );
  end
endmodule

// File: tb/tb_gpio_led_bank.sv
// Directed bench for gpio_led_bank with small counters; LED expectations come
// from an edge-count model, pin expectations from the directed schedule.

module tb_gpio_led_bank;
  localparam int N_LED = 8, N_IN = 3, PWM_BITS = 4, DB_CYCLES = 4, BLINK_BITS = 4;

  logic                clk = 1'b0;
  logic                resetn;
  logic [N_LED-1:0]    led_write;
  logic [2*N_LED-1:0]  led_mode;
  logic [PWM_BITS-1:0] led_duty;
  logic [N_LED-1:0]    io_led;
  logic [N_IN-1:0]     pin_in, pin_level, pin_rise, pin_fall;

  gpio_led_bank #(
    .N_LED(N_LED), .N_IN(N_IN), .PWM_BITS(PWM_BITS),
    .DB_CYCLES(DB_CYCLES), .BLINK_BITS(BLINK_BITS)
  ) dut (
    .clk(clk), .resetn(resetn), .led_write(led_write), .led_mode(led_mode),
    .led_duty(led_duty), .io_led(io_led), .pin_in(pin_in),
    .pin_level(pin_level), .pin_rise(pin_rise), .pin_fall(pin_fall)
  );

  always #5 clk = ~clk;

  // Edges seen since the last reset release.
  int cyc;
  always @(posedge clk or negedge resetn)
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;

  typedef struct {
    string      tag;
    logic [7:0] led;
    logic [8:0] pins;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [3:0]  m_duty;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cyc %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic step(input string tag, input logic [2:0] lvl,
                      input logic [2:0] rise, input logic [2:0] fall);
    exp_t e;
    int   p;
    logic pwm, blink;
    @(negedge clk);
    p     = cyc % 16;
    pwm   = p < int'(m_duty);
    blink = p >= 8;
    e.tag = tag;
    e.led = '0;
    for (int i = 0; i < N_LED; i++) begin
      case (led_mode[2*i +: 2])
        2'b01:   e.led[i] = led_write[i];
        2'b10:   e.led[i] = led_write[i] & pwm;
        2'b11:   e.led[i] = led_write[i] & blink;
        default: e.led[i] = 1'b0;
      endcase
    end
    e.pins = {lvl, rise, fall};
    q.push_back(e);
    if (p == 15) m_duty = led_duty;
    @(posedge clk); #1;
    e = q.pop_front();
    chk({e.tag, "_led"}, {8'h0, io_led}, {8'h0, e.led});
    chk({e.tag, "_pins"}, {7'h0, pin_level, pin_rise, pin_fall}, {7'h0, e.pins});
  endtask

  task automatic steps(input int n, input string tag, input logic [2:0] lvl);
    for (int k = 0; k < n; k++) step(tag, lvl, 3'b000, 3'b000);
  endtask

  initial begin
    resetn = 1'b0; pin_in = '0; led_write = '0; led_mode = '0; led_duty = '0;
    m_duty = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_led", {8'h0, io_led}, 16'h0);
    chk("reset_pins", {7'h0, pin_level, pin_rise, pin_fall}, 16'h0);
    resetn = 1'b1;

    // V1: static mode and off mode
    led_mode = 16'h5555; led_write = 8'h00;
    step("v1_off", 3'b000, 3'b000, 3'b000);
    led_write = 8'h01; step("v1_on", 3'b000, 3'b000, 3'b000);
    led_write = 8'hA5; step("v1_pat", 3'b000, 3'b000, 3'b000);
    led_mode = 16'h0000; led_write = 8'hFF;
    steps(2, "v1_mode0", 3'b000);

    // V2: PWM, including a mid-period duty change
    led_mode = 16'hAAAA; led_write = 8'hFF; led_duty = 4'd5;
    steps(40, "v2_d5", 3'b000);
    while (cyc % 16 != 6) step("v2_align", 3'b000, 3'b000, 3'b000);
    led_duty = 4'd12;
    steps(36, "v2_d12", 3'b000);
    led_duty = 4'd0;  steps(36, "v2_d0", 3'b000);
    led_duty = 4'd15; steps(36, "v2_d15", 3'b000);

    // V3: blink
    led_mode = 16'hFFFF; led_write = 8'hFF;
    steps(40, "v3_blink", 3'b000);
    led_mode = 16'h0000; led_write = 8'h00;

    // V4: rise on pin 1, then a 3-cycle glitch on pin 0
    pin_in = 3'b010;
    steps(5, "v4_wait", 3'b000);
    step("v4_rise", 3'b010, 3'b010, 3'b000);
    step("v4_hold", 3'b010, 3'b000, 3'b000);
    pin_in = 3'b011;
    steps(3, "v4_glitch", 3'b010);
    pin_in = 3'b010;
    steps(6, "v4_noev", 3'b010);

    // V5: simultaneous rises on pins 0 and 2, then fall on pin 0
    pin_in = 3'b111;
    steps(5, "v5_wait", 3'b010);
    step("v5_rise", 3'b111, 3'b101, 3'b000);
    step("v5_hold", 3'b111, 3'b000, 3'b000);
    pin_in = 3'b110;
    steps(5, "v5_wait2", 3'b111);
    step("v5_fall", 3'b110, 3'b000, 3'b001);
    step("v5_hold2", 3'b110, 3'b000, 3'b000);

    // V6: asynchronous reset mid-operation, then a pin held through release
    led_mode = 16'h5555; led_write = 8'hFF; led_duty = 4'd9;
    pin_in = 3'b000;
    steps(3, "v6_pre", 3'b110);
    #2 resetn = 1'b0;
    #1;
    chk("v6_async_led", {8'h0, io_led}, 16'h0);
    chk("v6_async_pins", {7'h0, pin_level, pin_rise, pin_fall}, 16'h0);
    pin_in = 3'b010;
    @(posedge clk); #1;
    chk("v6_held_led", {8'h0, io_led}, 16'h0);
    chk("v6_held_pins", {7'h0, pin_level, pin_rise, pin_fall}, 16'h0);
    m_duty = '0;
    resetn = 1'b1;
    steps(5, "v6_wait", 3'b000);
    step("v6_rise", 3'b010, 3'b010, 3'b000);
    steps(3, "v6_hold", 3'b010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
